// File: rtl/raxm_mac_accum.sv
// raxm_mac_accum: Wishbone-controlled accumulator for the approximate multiplier's 32-bit product stream.
// Optional build macro RAXM_ACC_SAT_EN makes the accumulator saturate instead of wrapping.
module raxm_mac_accum #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          ACC_W      = 48,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        prod_valid_i,
  input  logic [31:0] prod_data_i,
  output logic        prod_ready_o,
  output logic        done_irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LEN    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_RES_LO = 8'h0C;
  localparam logic [7:0] OFF_RES_HI = 8'h10;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      len_q, len_d;
  logic             signed_q, signed_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]      fifo_mem [FIFO_DEPTH];

  // Wishbone decode: a request is acted on only in the cycle it is first seen.
  logic       req, new_req, wr_en, rd_en;
  logic [7:0] offset;
  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign new_req = req & ~ack_q;
  assign wr_en   = new_req & wbs_we_i;
  assign rd_en   = new_req & ~wbs_we_i;
  assign offset  = wbs_adr_i[7:0];

  logic ctrl_wr, start, clear, done_clr;
  assign ctrl_wr  = wr_en & (offset == OFF_CTRL) & wbs_sel_i[0];
  assign start    = ctrl_wr & wbs_dat_i[0];
  assign clear    = ctrl_wr & wbs_dat_i[1];
  assign done_clr = wr_en & (offset == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[1];

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

  logic [PTR_W:0] fifo_level;
  logic           fifo_full, fifo_empty, push, pop;
  logic [31:0]    head;
  assign fifo_level   = wr_ptr_q - rd_ptr_q;
  assign fifo_full    = (fifo_level == FULL_LVL);
  assign fifo_empty   = (fifo_level == '0);
  assign prod_ready_o = wb_rst_ni & ~fifo_full;
  assign push         = prod_valid_i & prod_ready_o;
  assign pop          = (state_q == ST_RUN) & ~fifo_empty;
  assign head         = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  logic busy, done;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign done_irq_o = done;
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;

  // Extension and overflow detection for the head-of-FIFO product.
  logic [ACC_W-1:0] ext, acc_next;
  logic [ACC_W:0]   sum;
  logic             carry, sovf, ovf_evt;
  assign ext     = {{(ACC_W-32){signed_q & head[31]}}, head};
  assign sum     = {1'b0, acc_q} + {1'b0, ext};
  assign carry   = sum[ACC_W];
  assign sovf    = (acc_q[ACC_W-1] == ext[ACC_W-1]) & (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign ovf_evt = signed_q ? sovf : carry;

`ifdef RAXM_ACC_SAT_EN
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (ovf_evt) begin
      if (!signed_q)          acc_next = '1;
      else if (acc_q[ACC_W-1]) acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else                     acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  logic [31:0] status_w, rdata;
  assign status_w = {20'd0, 4'(fifo_level), 5'd0, ovf_q, done, busy};

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_CTRL:   rdata[2]    = signed_q;
      OFF_LEN:    rdata[15:0] = len_q;
      OFF_STATUS: rdata       = status_w;
      OFF_RES_LO: rdata       = acc_q[31:0];
      OFF_RES_HI: rdata       = 32'(acc_q[ACC_W-1:32]);
      default:    rdata       = '0;
    endcase
  end

  assign ack_d = new_req;
  assign dat_d = rd_en ? rdata : '0;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    len_d    = len_q;
    signed_d = ctrl_wr ? wbs_dat_i[2] : signed_q;
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);

    if (wr_en && offset == OFF_LEN) begin
      if (wbs_sel_i[0]) len_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) len_d[15:8] = wbs_dat_i[15:8];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && done_clr) state_d = ST_IDLE;
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len_q == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (pop) begin
          acc_d = acc_next;
          ovf_d = ovf_q | ovf_evt;
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == len_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including a product arriving on the same edge.
    if (clear) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      signed_q <= 1'b0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      signed_q <= signed_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= prod_data_i;
  end

endmodule

// File: tb/tb_raxm_mac_accum.sv
// Scoreboard bench for raxm_mac_accum: two instances (ACC_W=48 and ACC_W=33) share one Wishbone bus.
module tb_raxm_mac_accum;

  localparam logic [31:0] A_BASE = 32'h3000_0100;
  localparam logic [31:0] B_BASE = 32'h3000_0200;
  localparam logic [31:0] O_CTRL = 32'h00;
  localparam logic [31:0] O_LEN  = 32'h04;
  localparam logic [31:0] O_STAT = 32'h08;
  localparam logic [31:0] O_RLO  = 32'h0C;
  localparam logic [31:0] O_RHI  = 32'h10;
`ifdef RAXM_ACC_SAT_EN
  localparam logic [31:0] B_EXP_HI = 32'h0000_0001;
  localparam logic [31:0] B_EXP_LO = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] B_EXP_HI = 32'h0000_0000;
  localparam logic [31:0] B_EXP_LO = 32'hFFFF_FFFD;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_adr = '0, wb_wdat = '0;
  logic        ack_a, ack_b, ready_a, ready_b, irq_a, irq_b;
  logic [31:0] dat_a, dat_b;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [31:0] prod_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
    bit          chk;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  raxm_mac_accum #(.BASE_ADDR(A_BASE), .ACC_W(48), .FIFO_DEPTH(4)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we), .wbs_sel_i(wb_sel),
    .wbs_adr_i(wb_adr), .wbs_dat_i(wb_wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .prod_valid_i(valid_a), .prod_data_i(prod_data), .prod_ready_o(ready_a),
    .done_irq_o(irq_a)
  );

  raxm_mac_accum #(.BASE_ADDR(B_BASE), .ACC_W(33), .FIFO_DEPTH(4)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we), .wbs_sel_i(wb_sel),
    .wbs_adr_i(wb_adr), .wbs_dat_i(wb_wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .prod_valid_i(valid_b), .prod_data_i(prod_data), .prod_ready_o(ready_b),
    .done_irq_o(irq_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: every ack pops one scoreboard entry; between acks read data must be 0.
  always @(negedge clk) begin
    sb_t e;
    if (ack_a | ack_b) begin
      if (sb_q.size() == 0) begin
        check_bit("unexpected_ack", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check(e.name, (dat_a | dat_b) & e.mask, e.exp & e.mask);
      end
    end else begin
      check("dat_idle", dat_a | dat_b, 32'd0);
    end
  end

  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, input logic [31:0] exp, input logic [31:0] mask,
                          input string name, input bit hold);
    sb_t e;
    bit  acked;
    acked  = 1'b0;
    e.name = name;
    e.exp  = exp;
    e.mask = mask;
    e.chk  = !we;
    sb_q.push_back(e);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_wdat = wdat; wb_sel = sel;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ack_a | ack_b) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end
    if (hold) begin
      @(negedge clk);
      check_bit("ack_single", ack_a | ack_b, 1'b0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] base, input logic [31:0] off, input logic [31:0] d);
    wb_cycle(base + off, 1'b1, d, 4'hF, 32'd0, 32'd0, "wr", 1'b0);
  endtask

  task automatic rd(input logic [31:0] base, input logic [31:0] off, input logic [31:0] exp,
                    input string name);
    wb_cycle(base + off, 1'b0, 32'd0, 4'hF, exp, 32'hFFFF_FFFF, name, 1'b0);
  endtask

  task automatic push_one(input bit inst, input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    prod_data = v;
    if (inst) valid_b = 1'b1; else valid_a = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (inst ? ready_b : ready_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("push_timeout", 32'd0, 32'd1);
      valid_a = 1'b0; valid_b = 1'b0;
    end
  endtask

  task automatic push_end();
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_bit("rst_ack", ack_a | ack_b, 1'b0);
    check("rst_dat", dat_a | dat_b, 32'd0);
    check_bit("rst_irq", irq_a | irq_b, 1'b0);
    check_bit("rst_ready", ready_a | ready_b, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("ready_after_rst", ready_a, 1'b1);
    rd(A_BASE, O_STAT, 32'h0, "stat_rst");
    rd(A_BASE, O_RHI, 32'h0, "rhi_rst");

    // Byte selects, unmapped offset, single-cycle ack with held strobe
    wb_cycle(A_BASE + O_LEN, 1'b1, 32'h0000_1234, 4'h3, 32'd0, 32'd0, "wr", 1'b0);
    wb_cycle(A_BASE + O_LEN, 1'b1, 32'h0000_ABCD, 4'h2, 32'd0, 32'd0, "wr", 1'b0);
    wb_cycle(A_BASE + O_LEN, 1'b0, 32'd0, 4'hF, 32'h0000_AB34, 32'hFFFF_FFFF, "len_bytesel", 1'b1);
    wr(A_BASE, 32'h14, 32'hFFFF_FFFF);
    rd(A_BASE, 32'h14, 32'h0, "unmapped");

    // Test 1: unsigned, LEN=4, 3+5+7+9
    wr(A_BASE, O_LEN, 32'd4);
    wr(A_BASE, O_CTRL, 32'h1);
    rd(A_BASE, O_STAT, 32'h1, "t1_busy");
    push_one(1'b0, 32'd3); push_one(1'b0, 32'd5); push_one(1'b0, 32'd7); push_one(1'b0, 32'd9);
    push_end();
    check_bit("t1_irq_before_4th_pop", irq_a, 1'b0);
    @(negedge clk);
    check_bit("t1_irq_on_4th_pop", irq_a, 1'b1);
    rd(A_BASE, O_STAT, 32'h2, "t1_status");
    rd(A_BASE, O_RLO, 32'd24, "t1_res_lo");
    rd(A_BASE, O_RHI, 32'd0, "t1_res_hi");
    rd(A_BASE, O_CTRL, 32'd0, "t1_ctrl");

    // Test 2: signed, three products of -1
    wr(A_BASE, O_LEN, 32'd3);
    wr(A_BASE, O_CTRL, 32'h5);
    repeat (3) push_one(1'b0, 32'hFFFF_FFFF);
    push_end();
    idle(2);
    rd(A_BASE, O_RLO, 32'hFFFF_FFFD, "t2_res_lo");
    rd(A_BASE, O_RHI, 32'h0000_FFFF, "t2_res_hi");
    rd(A_BASE, O_CTRL, 32'h4, "t2_ctrl_signed");
    check_bit("t2_irq", irq_a, 1'b1);
    wr(A_BASE, O_STAT, 32'h2);
    check_bit("t2_irq_cleared", irq_a, 1'b0);
    wb_cycle(A_BASE + O_STAT, 1'b0, 32'd0, 4'hF, 32'h0, 32'h0000_0F03, "t2_idle", 1'b0);
    wr(A_BASE, O_CTRL, 32'h0);

    // Test 3: FIFO fills while idle, then drains
    for (int i = 1; i <= 4; i++) push_one(1'b0, i);
    push_end();
    check_bit("t3_ready_full", ready_a, 1'b0);
    rd(A_BASE, O_STAT, 32'h400, "t3_level4");
    fork
      begin
        push_one(1'b0, 32'd5); push_one(1'b0, 32'd6); push_end();
      end
      begin
        wr(A_BASE, O_LEN, 32'd6); wr(A_BASE, O_CTRL, 32'h1);
      end
    join
    idle(6);
    rd(A_BASE, O_STAT, 32'h2, "t3_done_level0");
    rd(A_BASE, O_RLO, 32'd21, "t3_sum");
    wr(A_BASE, O_STAT, 32'h2);

    // Test 4: LEN=0, then START ignored in RUN
    wr(A_BASE, O_LEN, 32'd0);
    wr(A_BASE, O_CTRL, 32'h1);
    check_bit("t4_len0_irq", irq_a, 1'b1);
    rd(A_BASE, O_RLO, 32'd0, "t4_len0_res_lo");
    rd(A_BASE, O_RHI, 32'd0, "t4_len0_res_hi");
    wr(A_BASE, O_LEN, 32'd4);
    wr(A_BASE, O_CTRL, 32'h1);
    push_one(1'b0, 32'd10); push_one(1'b0, 32'd20); push_end();
    idle(2);
    rd(A_BASE, O_RLO, 32'd30, "t4_live_acc");
    wr(A_BASE, O_CTRL, 32'h1);
    rd(A_BASE, O_STAT, 32'h1, "t4_still_busy");
    push_one(1'b0, 32'd30); push_one(1'b0, 32'd40); push_end();
    idle(3);
    rd(A_BASE, O_STAT, 32'h2, "t4_done");
    rd(A_BASE, O_RLO, 32'd100, "t4_sum");
    wr(A_BASE, O_STAT, 32'h2);

    // Test 5: CLEAR after 2 of 5, with a product pushed on the CLEAR edge
    wr(A_BASE, O_LEN, 32'd5);
    wr(A_BASE, O_CTRL, 32'h1);
    push_one(1'b0, 32'd7); push_one(1'b0, 32'd8); push_end();
    idle(2);
    rd(A_BASE, O_RLO, 32'd15, "t5_partial");
    fork
      wr(A_BASE, O_CTRL, 32'h2);
      begin push_one(1'b0, 32'd99); push_end(); end
    join
    rd(A_BASE, O_STAT, 32'h0, "t5_clr_status");
    rd(A_BASE, O_RLO, 32'd0, "t5_clr_res_lo");
    rd(A_BASE, O_RHI, 32'd0, "t5_clr_res_hi");
    rd(A_BASE, O_LEN, 32'd5, "t5_len_kept");
    check_bit("t5_irq", irq_a, 1'b0);
    wr(A_BASE, O_LEN, 32'd1);
    wr(A_BASE, O_CTRL, 32'h1);
    idle(2);
    rd(A_BASE, O_STAT, 32'h1, "t5_flushed");
    push_one(1'b0, 32'd9); push_end();
    idle(2);
    rd(A_BASE, O_STAT, 32'h2, "t5_after_flush_done");
    rd(A_BASE, O_RLO, 32'd9, "t5_after_flush_sum");
    wr(A_BASE, O_STAT, 32'h2);

    // Test 6: ACC_W=33 unsigned overflow on instance B
    wr(B_BASE, O_LEN, 32'd3);
    wr(B_BASE, O_CTRL, 32'h1);
    repeat (3) push_one(1'b1, 32'hFFFF_FFFF);
    push_end();
    idle(3);
    rd(B_BASE, O_RHI, B_EXP_HI, "t6_res_hi");
    rd(B_BASE, O_RLO, B_EXP_LO, "t6_res_lo");
    rd(B_BASE, O_STAT, 32'h6, "t6_status_ovf");
    check_bit("t6_irq", irq_b, 1'b1);

    // Test 5b: asynchronous reset mid-RUN, while an ack is on the bus
    wr(A_BASE, O_LEN, 32'd5);
    wr(A_BASE, O_CTRL, 32'h1);
    push_one(1'b0, 32'd3); push_end();
    begin
      sb_t e;
      e.name = "rst_len_read"; e.exp = 32'd5; e.mask = 32'hFFFF_FFFF; e.chk = 1'b1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = A_BASE + O_LEN; wb_sel = 4'hF;
    @(negedge clk);
    check_bit("pre_rst_ack", ack_a, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_bit("async_rst_ack", ack_a, 1'b0);
    check("async_rst_dat", dat_a, 32'd0);
    check_bit("async_rst_ready", ready_a, 1'b0);
    check_bit("async_rst_irq_b", irq_b, 1'b0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("post_rst_ready", ready_a, 1'b1);
    rd(A_BASE, O_STAT, 32'h0, "post_rst_status_a");
    rd(A_BASE, O_LEN, 32'h0, "post_rst_len_a");
    rd(A_BASE, O_RLO, 32'h0, "post_rst_res_a");
    rd(B_BASE, O_STAT, 32'h0, "post_rst_status_b");
    idle(2);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
